updown_counter_mod_311: RTL and testbench

//  Parametrised modulo up/down counter with synchronous load, enable, and wrap or one-shot mode.

---
 rtl/counter_pkg_311.sv | 15 +
 rtl/updown_counter_mod_311_if.sv | 23 ++
 rtl/count_step_311.sv | 27 ++
 rtl/updown_counter_mod_311.sv | 64 ++++++
 tb/tb_updown_counter_mod_311.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/counter_pkg_311.sv
// Shared encodings for the modulo up/down counter: FSM states, mode and direction constants.
package counter_pkg_311;

    typedef enum logic {
        ST_RUN_311  = 1'b0,
        ST_HALT_311 = 1'b1
    } state_311_e;

    localparam logic MODE_WRAP_311    = 1'b0;
    localparam logic MODE_ONESHOT_311 = 1'b1;

    localparam logic DIR_DOWN_311 = 1'b0;
    localparam logic DIR_UP_311   = 1'b1;

endpackage

// File: rtl/updown_counter_mod_311_if.sv
// Control/status bundle of the modulo up/down counter; the counter is the slave side.
interface updown_counter_mod_311_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en_311;
    logic             up_dn_311;
    logic             mode_311;
    logic             load_311;
    logic [WIDTH-1:0] load_val_311;
    logic [WIDTH-1:0] count_311;
    logic             tc_311;
    logic             done_311;

    modport master (
        output en_311, up_dn_311, mode_311, load_311, load_val_311,
        input  count_311, tc_311, done_311
    );

    modport slave (
        input  en_311, up_dn_311, mode_311, load_311, load_val_311,
        output count_311, tc_311, done_311
    );
endinterface

// File: rtl/count_step_311.sv
// One-step successor of the count in the selected direction, wrapping at 0 / MAX_VAL, plus the
// terminal flag that says this step would cross the range boundary.
module count_step_311
    import counter_pkg_311::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_count,
    output logic             terminal
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    always_comb begin
        terminal   = (up_dn == DIR_UP_311) ? (count == MAX_C) : (count == '0);
        next_count = count;
        if (terminal) begin
            next_count = (up_dn == DIR_UP_311) ? '0 : MAX_C;
        end else if (up_dn == DIR_UP_311) begin
            next_count = count + 1'b1;
        end else begin
            next_count = count - 1'b1;
        end
    end
endmodule

// File: rtl/updown_counter_mod_311.sv
// Modulo up/down counter with clamped synchronous load, wrap or one-shot mode, a one-cycle
// terminal-count pulse and a done flag held while halted. All state changes on negedge clk_311.
module updown_counter_mod_311
    import counter_pkg_311::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned INIT_VAL = MAX_VAL
) (
    input  logic                     clk_311,
    input  logic                     reset_311,
    updown_counter_mod_311_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    state_311_e       state_q;

    logic [WIDTH-1:0] next_count;
    logic             terminal;
    logic [WIDTH-1:0] load_clamped;

    count_step_311 #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .count      (count_q),
        .up_dn      (bus.up_dn_311),
        .next_count (next_count),
        .terminal   (terminal)
    );

    assign load_clamped = (bus.load_val_311 > MAX_C) ? MAX_C : bus.load_val_311;

    always_ff @(negedge clk_311) begin
        if (reset_311) begin
            count_q <= INIT_C;
            tc_q    <= 1'b0;
            state_q <= ST_RUN_311;
        end else if (bus.load_311) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
            state_q <= ST_RUN_311;
        end else if (state_q == ST_HALT_311) begin
            tc_q <= 1'b0;
        end else if (bus.en_311) begin
            tc_q <= terminal;
            // One-shot parks on the terminal value instead of wrapping.
            if (terminal && bus.mode_311 == MODE_ONESHOT_311) begin
                state_q <= ST_HALT_311;
            end else begin
                count_q <= next_count;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.count_311 = count_q;
    assign bus.tc_311    = tc_q;
    assign bus.done_311  = (state_q == ST_HALT_311);
endmodule

// File: tb/tb_updown_counter_mod_311.sv
// Three counter instances (MAX 255 / 9 / 99) share one stimulus; directed table plus random
// stimulus checked against a rule-level reference model.
module tb_updown_counter_mod_311;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       mode;
    logic       load;
    logic [7:0] lval;

    updown_counter_mod_311_if #(.WIDTH(8)) if0 ();
    updown_counter_mod_311_if #(.WIDTH(8)) if1 ();
    updown_counter_mod_311_if #(.WIDTH(8)) if2 ();

    assign if0.en_311 = en;   assign if0.up_dn_311 = up;   assign if0.mode_311 = mode;
    assign if0.load_311 = load;   assign if0.load_val_311 = lval;
    assign if1.en_311 = en;   assign if1.up_dn_311 = up;   assign if1.mode_311 = mode;
    assign if1.load_311 = load;   assign if1.load_val_311 = lval;
    assign if2.en_311 = en;   assign if2.up_dn_311 = up;   assign if2.mode_311 = mode;
    assign if2.load_311 = load;   assign if2.load_val_311 = lval;

    updown_counter_mod_311 u_dut0 (
        .clk_311   (clk),
        .reset_311 (rst),
        .bus       (if0)
    );

    updown_counter_mod_311 #(.WIDTH(8), .MAX_VAL(9), .INIT_VAL(3)) u_dut1 (
        .clk_311   (clk),
        .reset_311 (rst),
        .bus       (if1)
    );

    updown_counter_mod_311 #(.WIDTH(8), .MAX_VAL(99)) u_dut2 (
        .clk_311   (clk),
        .reset_311 (rst),
        .bus       (if2)
    );

    logic [7:0] o_cnt  [3];
    logic       o_tc   [3];
    logic       o_done [3];

    assign o_cnt[0] = if0.count_311;  assign o_tc[0] = if0.tc_311;  assign o_done[0] = if0.done_311;
    assign o_cnt[1] = if1.count_311;  assign o_tc[1] = if1.tc_311;  assign o_done[1] = if1.done_311;
    assign o_cnt[2] = if2.count_311;  assign o_tc[2] = if2.tc_311;  assign o_done[2] = if2.done_311;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one record of the counter's observable state per instance.
    int mmax  [3] = '{255, 9, 99};
    int minit [3] = '{255, 3, 99};
    int mcnt  [3];
    int mtc   [3];
    int mdone [3];

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mcnt[d] = minit[d]; mtc[d] = 0; mdone[d] = 0;
            end else if (load) begin
                mcnt[d] = (int'(lval) > mmax[d]) ? mmax[d] : int'(lval);
                mtc[d] = 0; mdone[d] = 0;
            end else if (mdone[d] != 0 || !en) begin
                mtc[d] = 0;
            end else if (up ? (mcnt[d] == mmax[d]) : (mcnt[d] == 0)) begin
                mtc[d] = 1;
                if (mode) mdone[d] = 1;
                else      mcnt[d] = up ? 0 : mmax[d];
            end else begin
                mcnt[d] = up ? mcnt[d] + 1 : mcnt[d] - 1;
                mtc[d] = 0;
            end
        end
    endtask

    typedef struct {
        int d;
        bit rst, en, up, mode, load;
        int lval;
        int cnt;
        bit tc, done;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; mode = 1'b0; load = 1'b0; lval = 8'd0;

        // dut0 defaults: reset, then count down three edges
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0,   255, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0,   254, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0,   253, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0,   252, 0, 0});
        // dut1 (MAX 9) wrap up from 8
        tbl.push_back('{1, 0, 0, 1, 0, 1, 8,   8, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0,   9, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0,   0, 1, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0,   1, 0, 0});
        // dut1 one-shot down from 2, then halted for 5 edges with other inputs ignored
        tbl.push_back('{1, 0, 0, 0, 1, 1, 2,   2, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0,   1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0,   0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0,   0, 1, 1});
        for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 1, 1, 0, 0, 0,   0, 0, 1});
        // load out of HALT with en high: no step on the load edge
        tbl.push_back('{1, 0, 1, 0, 0, 1, 5,   5, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0,   4, 0, 0});
        // dut2 (MAX 99): clamp, load beats en, wrap at top
        tbl.push_back('{2, 0, 0, 0, 0, 1, 200, 99, 0, 0});
        tbl.push_back('{2, 0, 1, 1, 0, 1, 10,  10, 0, 0});
        tbl.push_back('{2, 0, 0, 1, 0, 1, 98,  98, 0, 0});
        tbl.push_back('{2, 0, 1, 1, 0, 0, 0,   99, 0, 0});
        tbl.push_back('{2, 0, 1, 1, 0, 0, 0,   0, 1, 0});
        tbl.push_back('{2, 0, 1, 1, 0, 0, 0,   1, 0, 0});
        // reset mid-count, and reset out of HALT overriding a load
        tbl.push_back('{2, 0, 0, 0, 0, 1, 37,  37, 0, 0});
        tbl.push_back('{2, 1, 1, 1, 0, 0, 0,   99, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 1,   1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0,   0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0,   0, 1, 1});
        tbl.push_back('{1, 1, 1, 0, 1, 1, 7,   3, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,   3, 0, 0});

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; up = tbl[i].up; mode = tbl[i].mode;
            load = tbl[i].load; lval = 8'(tbl[i].lval);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d.count", i), int'(o_cnt[tbl[i].d]), tbl[i].cnt);
            chk($sformatf("vec%0d.tc", i), int'(o_tc[tbl[i].d]), int'(tbl[i].tc));
            chk($sformatf("vec%0d.done", i), int'(o_done[tbl[i].d]), int'(tbl[i].done));
        end

        rst = 1'b1; en = 1'b0; load = 1'b0;
        model_step();
        @(negedge clk);
        #1;
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom);
            mode = ($urandom_range(0, 2) == 0) ? ~mode : mode;
            lval = 8'($urandom);
            model_step();
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rnd%0d.dut%0d.count", n, d), int'(o_cnt[d]), mcnt[d]);
                chk($sformatf("rnd%0d.dut%0d.tc", n, d), int'(o_tc[d]), mtc[d]);
                chk($sformatf("rnd%0d.dut%0d.done", n, d), int'(o_done[d]), mdone[d]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
